// File: rtl/serial_frame_tx_pkg.sv
// Purpose : shared types and defaults for the framed serial transmitter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package serial_frame_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int BIT_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Counter width for a modulo-n count; never below one bit so n=1 still
  // yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Purpose : frame request / status bundle between the sequencer and the transmitter.
// Latency : n/a (wiring only).
// Backpressure: none; refused requests are reported through the sticky overrun flag.
// Signals : load (request level), din (parallel word), serial_out (line),
//           busy (frame active), done (completion pulse), overrun (sticky refusal).
interface serial_frame_tx_if
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              load;
  logic [DATA_W-1:0] din;
  logic              serial_out;
  logic              busy;
  logic              done;
  logic              overrun;

  // Sequencer side.
  modport master (
    output load,
    output din,
    input  serial_out,
    input  busy,
    input  done,
    input  overrun
  );

  // Transmitter side.
  modport slave (
    input  load,
    input  din,
    output serial_out,
    output busy,
    output done,
    output overrun
  );
endinterface

// File: rtl/serial_frame_tx_bit_tick_counter.sv
// Purpose : divides the clock into serial bit periods of BIT_CYCLES clocks.
// Latency : tick is combinational from the count, high on the last clock of each period.
// Backpressure: none; clr holds the count at zero while no frame is running.
// Ports   : clock, reset_n, clr (hold at zero), tick (period end).
module bit_tick_counter
  import serial_frame_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(BIT_CYCLES);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(BIT_CYCLES - 1));

  // Wraps from BIT_CYCLES-1 to 0; with BIT_CYCLES=1 the count stays at zero
  // and every clock is a tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Purpose : captures a parallel word on a load rising edge and sends start, DATA_W bits LSB first, stop.
// Latency : serial_out/busy change right after the accepting edge; frame = (DATA_W+2)*BIT_CYCLES clocks.
// Backpressure: load edges seen while a frame is active are dropped and set the sticky overrun flag.
// Ports   : clock, reset_n (async, active low), bus (slave side of serial_frame_tx_if).
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  serial_frame_tx_if.slave  bus
);

  localparam int IW = cnt_width(DATA_W);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [IW-1:0]     bidx;
  logic [IW-1:0]     bidx_nxt;
  logic              load_d;
  logic              load_edge;
  logic              tick;
  logic              out_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              refuse;

  assign load_edge = bus.load & ~load_d;
  assign refuse    = load_edge & (state != IDLE);

  // The bit timer is parked at zero in IDLE, so the START period always
  // begins a full BIT_CYCLES window on the accepting edge.
  bit_tick_counter #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state == IDLE),
    .tick    (tick)
  );

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bidx_nxt  = bidx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load_edge) begin
          state_nxt = START;
          shreg_nxt = bus.din;
          bidx_nxt  = '0;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nxt = shreg >> 1;
          if (bidx == IW'(DATA_W - 1)) begin
            state_nxt = STOP;
          end else begin
            bidx_nxt = bidx + IW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Line level is derived from the next state so serial_out can be a flop
    // and still change on the same edge as the state.
    case (state_nxt)
      START:   out_nxt = 1'b0;
      DATA:    out_nxt = shreg_nxt[0];
      default: out_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // load_d resets high so a load already asserted at reset release is not
  // mistaken for a new request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_d         <= 1'b1;
      shreg          <= '0;
      bidx           <= '0;
      bus.serial_out <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      load_d         <= bus.load;
      shreg          <= shreg_nxt;
      bidx           <= bidx_nxt;
      bus.serial_out <= out_nxt;
      bus.busy       <= busy_nxt;
      bus.done       <= done_nxt;
      if (refuse) begin
        bus.overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Purpose : directed bench for serial_frame_tx, one instance at BIT_CYCLES=1 and one at 4.
// Latency : outputs sampled 1 time unit after each rising clock edge.
// Backpressure: exercises refused load edges and the sticky overrun flag.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clock = ~clock;

  serial_frame_tx_if #(.DATA_W(8)) ifa ();
  serial_frame_tx_if #(.DATA_W(8)) ifb ();

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Line level for frame slot pos: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] w, input int pos);
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    return w[pos-1];
  endfunction

  initial begin
    int done_cnt;
    int busy_cnt;
    ifa.load = 1'b0;
    ifa.din  = 8'h00;
    ifb.load = 1'b0;
    ifb.din  = 8'h00;

    // Reset state
    repeat (2) step();
    chk("rst_ser_b",  ifb.serial_out, 1);
    chk("rst_busy_b", ifb.busy,       0);
    chk("rst_done_b", ifb.done,       0);
    chk("rst_ovr_b",  ifb.overrun,    0);
    chk("rst_ser_a",  ifa.serial_out, 1);
    reset_n = 1'b1;
    step();

    // First word, one clock per bit
    ifa.din  = 8'hA5;
    ifa.load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) ifa.load = 1'b0;
      chk($sformatf("a5_ser%0d", i), ifa.serial_out, frame_bit(8'hA5, i - 1));
      chk($sformatf("a5_busy%0d", i), ifa.busy, 1);
      chk($sformatf("a5_done%0d", i), ifa.done, 0);
    end
    step();
    chk("a5_done_end", ifa.done, 1);
    chk("a5_busy_end", ifa.busy, 0);
    chk("a5_ser_end",  ifa.serial_out, 1);
    chk("a5_ovr_end",  ifa.overrun, 0);
    step();
    chk("a5_done_clr", ifa.done, 0);

    // Second word at four clocks per bit, with a refused edge at clock 5
    ifb.din  = 8'h47;
    ifb.load = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) ifb.load = 1'b0;
      if (i == 2) ifb.din = 8'hFF;
      chk($sformatf("47_ser%0d", i), ifb.serial_out, frame_bit(8'h47, (i - 1) / 4));
      chk($sformatf("47_busy%0d", i), ifb.busy, 1);
      chk($sformatf("47_done%0d", i), ifb.done, 0);
      chk($sformatf("47_ovr%0d", i), ifb.overrun, (i >= 5) ? 1 : 0);
      if (i == 4) ifb.load = 1'b1;
      if (i == 5) ifb.load = 1'b0;
    end
    step();
    chk("47_done_end", ifb.done, 1);
    chk("47_busy_end", ifb.busy, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("47_after_busy%0d", i), ifb.busy, 0);
      chk($sformatf("47_after_ser%0d", i), ifb.serial_out, 1);
      chk($sformatf("47_after_ovr%0d", i), ifb.overrun, 1);
    end

    // Load edge on the final stop clock is refused
    ifa.din  = 8'h5A;
    ifa.load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) ifa.load = 1'b0;
      chk($sformatf("5a_ser%0d", i), ifa.serial_out, frame_bit(8'h5A, i - 1));
      chk($sformatf("5a_ovr%0d", i), ifa.overrun, 0);
      if (i == 10) ifa.load = 1'b1;
    end
    step();
    chk("5a_done_end", ifa.done, 1);
    chk("5a_busy_end", ifa.busy, 0);
    chk("5a_ovr_end",  ifa.overrun, 1);
    step();
    chk("5a_refused_busy", ifa.busy, 0);
    chk("5a_refused_ser",  ifa.serial_out, 1);
    ifa.load = 1'b0;
    step();

    // Load edge one clock after the final stop clock is accepted
    ifa.din  = 8'h81;
    ifa.load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) ifa.load = 1'b0;
      chk($sformatf("81_ser%0d", i), ifa.serial_out, frame_bit(8'h81, i - 1));
    end
    step();
    chk("81_done_end", ifa.done, 1);
    ifa.din  = 8'hC3;
    ifa.load = 1'b1;
    step();
    ifa.load = 1'b0;
    chk("c3_acc_busy", ifa.busy, 1);
    chk("c3_acc_ser",  ifa.serial_out, 0);
    chk("c3_acc_done", ifa.done, 0);
    for (int j = 1; j <= 9; j++) begin
      step();
      chk($sformatf("c3_ser%0d", j), ifa.serial_out, frame_bit(8'hC3, j));
    end
    step();
    chk("c3_done_end", ifa.done, 1);

    // Held load with din changing mid-frame
    ifb.din  = 8'h3C;
    ifb.load = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (i == 3) ifb.din = 8'hFF;
      if (i <= 40) chk($sformatf("3c_ser%0d", i), ifb.serial_out, frame_bit(8'h3C, (i - 1) / 4));
      if (ifb.done) done_cnt++;
      if (ifb.busy) busy_cnt++;
    end
    ifb.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ifb.done) done_cnt++;
      if (ifb.busy) busy_cnt++;
    end
    chk("3c_done_cnt", done_cnt, 1);
    chk("3c_busy_cnt", busy_cnt, 40);

    // Asynchronous reset mid-frame, then release with load held high
    ifb.din  = 8'h00;
    ifb.load = 1'b1;
    repeat (10) step();
    chk("mid_busy_pre", ifb.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ser",  ifb.serial_out, 1);
    chk("mid_rst_busy", ifb.busy,       0);
    chk("mid_rst_done", ifb.done,       0);
    chk("mid_rst_ovr",  ifb.overrun,    0);
    repeat (2) step();
    reset_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (ifb.done) done_cnt++;
      if (ifb.busy) busy_cnt++;
    end
    chk("rel_busy_cnt", busy_cnt, 0);
    chk("rel_done_cnt", done_cnt, 0);
    chk("rel_ser",      ifb.serial_out, 1);
    ifb.load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
